// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers, one result bit per cycle.
// Optional feature macro MULDIV_ACC_EN: ops 100/101 accumulate the product into {hi,lo}.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

   state_t               state;
   logic [CW-1:0]        count;
   logic [WIDTH-1:0]     mcand;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH:0]       rem;
   logic                 is_div;
   logic                 dbz;
   logic                 res_neg;
   logic                 rem_neg;
`ifdef MULDIV_ACC_EN
   logic                 acc_op;
`endif

   logic                 op_valid;
   logic                 op_div;
   logic                 a_neg;
   logic                 b_neg;
   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_diff;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [2*WIDTH-1:0]   mul_res;

   function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] x, input logic n);
      return n ? ('0 - x) : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] x, input logic n);
      return n ? ('0 - x) : x;
   endfunction

   always_comb begin
      op_valid  = (op[2:1] != 2'b11);
      op_div    = (op[2:1] == 2'b01);
      a_neg     = ~op[0] & a[WIDTH-1];
      b_neg     = ~op[0] & b[WIDTH-1];
      a_mag     = cneg(a, a_neg);
      b_mag     = cneg(b, b_neg);
      // Shift-add: the multiplier sits in the low half and is consumed LSB first.
      mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
      // Restoring divide: dividend/quotient share the low half of prod, MSB first.
      div_shift = {rem[WIDTH-1:0], prod[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mcand};
      prod_fix  = cneg2(prod, res_neg);
`ifdef MULDIV_ACC_EN
      mul_res   = acc_op ? ({hi, lo} + prod_fix) : prod_fix;
`else
      mul_res   = prod_fix;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         mcand       <= '0;
         prod        <= '0;
         rem         <= '0;
         is_div      <= 1'b0;
         dbz         <= 1'b0;
         res_neg     <= 1'b0;
         rem_neg     <= 1'b0;
`ifdef MULDIV_ACC_EN
         acc_op      <= 1'b0;
`endif
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start && op_valid) begin
                  is_div  <= op_div;
                  dbz     <= op_div && (b == '0);
                  res_neg <= a_neg ^ b_neg;
                  rem_neg <= a_neg;
`ifdef MULDIV_ACC_EN
                  acc_op  <= op[2];
`endif
                  count   <= CW'(WIDTH - 1);
                  mcand   <= op_div ? b_mag : a_mag;
                  prod    <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                  rem     <= '0;
                  busy    <= 1'b1;
                  if (op_div && (b == '0))
                     state <= FIN;
                  else
                     state <= op_div ? DIV : MUL;
               end else begin
                  if (mthi) hi <= a;
                  if (mtlo) lo <= a;
               end
            end
            MUL: begin
               prod  <= {mul_sum, prod[WIDTH-1:1]};
               count <= count - 1'b1;
               if (count == '0) state <= FIN;
            end
            DIV: begin
               if (div_diff[WIDTH]) begin
                  rem  <= div_shift;
                  prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], 1'b0};
               end else begin
                  rem  <= div_diff;
                  prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], 1'b1};
               end
               count <= count - 1'b1;
               if (count == '0) state <= FIN;
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
               if (dbz) begin
                  div_by_zero <= 1'b1;
               end else if (is_div) begin
                  lo <= cneg(prod[WIDTH-1:0], res_neg);
                  hi <= cneg(rem[WIDTH-1:0], rem_neg);
               end else begin
                  {hi, lo} <= mul_res;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: expected HI/LO from a plain-arithmetic model, checked on done.
module tb_ex_muldiv;
   logic        clk = 1'b0;
   logic        rst_n, start, mthi, mtlo;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int checks = 0;
   int fails  = 0;
   logic [64:0] sb[$];
   logic [31:0] mh = '0, ml = '0;

   ex_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
      .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse consumes one scoreboard entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_done: got done=1, expected no pending op");
         end else begin
            logic [64:0] ent;
            ent = sb.pop_front();
            chk("sb_hi", {32'h0, hi}, {32'h0, ent[63:32]});
            chk("sb_lo", {32'h0, lo}, {32'h0, ent[31:0]});
            chk("sb_dbz", {63'h0, div_by_zero}, {63'h0, ent[64]});
            chk("busy_low_on_done", {63'h0, busy}, 64'h0);
         end
      end
   end

   // Reference model: MIPS HI/LO semantics via 64-bit integer arithmetic.
   task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] e, output logic dz);
      longint sx, sy, q, r;
      logic [63:0] ux, uy, p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'h0, x};
      uy = {32'h0, y};
      dz = 1'b0;
      e  = {mh, ml};
      case (o)
         3'd0, 3'd4, 3'd1, 3'd5: begin
            if (o[0]) p = ux * uy;
            else      p = 64'(sx * sy);
`ifdef MULDIV_ACC_EN
            if (o[2]) p = {mh, ml} + p;
`endif
            e = p;
         end
         3'd2: begin
            if (y == 0) dz = 1'b1;
            else begin
               q = sx / sy;
               r = sx % sy;
               e = {r[31:0], q[31:0]};
            end
         end
         3'd3: begin
            if (y == 0) dz = 1'b1;
            else begin
               p = ux / uy;
               uy = ux % uy;
               e = {uy[31:0], p[31:0]};
            end
         end
         default: ;
      endcase
   endtask

   task automatic write_hl(input logic hw, input logic lw, input logic [31:0] x);
      @(negedge clk);
      a = x; mthi = hw; mtlo = lw;
      @(posedge clk); #1;
      mthi = 1'b0; mtlo = 1'b0;
      if (hw) mh = x;
      if (lw) ml = x;
      chk("mthi_hi", {32'h0, hi}, {32'h0, mh});
      chk("mtlo_lo", {32'h0, lo}, {32'h0, ml});
   endtask

   task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic hw, input logic lw, input int inject_at, input int reset_at);
      logic [63:0] e;
      logic dz;
      int n, lat;
      bit valid;
      valid = (o[2:1] != 2'b11);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1; mthi = hw; mtlo = lw;
      if (valid) begin
         model(o, x, y, e, dz);
         sb.push_back({dz, e});
         mh = e[63:32];
         ml = e[31:0];
      end else begin
         if (hw) mh = x;
         if (lw) ml = x;
         dz = 1'b0;
      end
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      if (!valid) begin
         chk("bad_op_idle", {63'h0, busy}, 64'h0);
         chk("bad_op_hilo", {hi, lo}, {mh, ml});
         return;
      end
      chk("busy_after_start", {63'h0, busy}, 64'h1);
      lat = dz ? 1 : 33;
      n = 0;
      while (!done && n < 100) begin
         if (n == inject_at) begin
            start = 1'b1; op = 3'b010; mthi = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0;
         end
         if (n == reset_at) rst_n = 1'b0;
         @(posedge clk); #1;
         n++;
         start = 1'b0; mthi = 1'b0;
         if (rst_n == 1'b0) begin
            chk("abort_busy", {63'h0, busy}, 64'h0);
            chk("abort_done", {63'h0, done}, 64'h0);
            chk("abort_hilo", {hi, lo}, 64'h0);
            rst_n = 1'b1;
            void'(sb.pop_back());
            mh = '0;
            ml = '0;
            return;
         end
         if (!done) chk("busy_in_flight", {63'h0, busy}, 64'h1);
      end
      chk("latency", 64'(n), 64'(lat));
      chk("busy_clear", {63'h0, busy}, 64'h0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      op = 3'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hilo", {hi, lo}, 64'h0);
      chk("rst_ctrl", {61'h0, busy, done, div_by_zero}, 64'h0);
      rst_n = 1'b1;

      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0, -1, -1);
      chk("mult_7_m3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(3'd3, 32'd100, 32'd7, 1'b0, 1'b0, -1, -1);
      chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, -1, -1);
      chk("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, -1, -1);
      chk("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);

      write_hl(1'b1, 1'b0, 32'h1234);
      do_op(3'd2, 32'd5, 32'd0, 1'b0, 1'b0, -1, -1);
      chk("dbz_hilo", {hi, lo}, {32'h1234, 32'h8000_0000});

      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 9, -1);
      chk("multu_inject", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      do_op(3'd0, 32'd123, 32'd456, 1'b0, 1'b0, -1, 14);
      do_op(3'd0, 32'd3, 32'd4, 1'b0, 1'b0, -1, -1);
      chk("mult_after_rst", {hi, lo}, 64'd12);

      write_hl(1'b1, 1'b1, 32'h0);
      write_hl(1'b0, 1'b1, 32'hFFFF_FFFF);
      do_op(3'd5, 32'd1, 32'd1, 1'b0, 1'b0, -1, -1);
`ifdef MULDIV_ACC_EN
      chk("maddu_acc", {hi, lo}, {32'd1, 32'd0});
`else
      chk("maddu_plain", {hi, lo}, {32'd0, 32'd1});
`endif

      do_op(3'd6, 32'd9, 32'd9, 1'b0, 1'b0, -1, -1);
      do_op(3'd0, 32'd2, 32'd2, 1'b1, 1'b1, -1, -1);

      for (int i = 0; i < 40; i++) begin
         logic [2:0] o;
         o = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 4) == 0)
            write_hl(1'($urandom), 1'($urandom), $urandom);
         if (o[2:1] == 2'b11)
            do_op(o, pick(), pick(), 1'b0, 1'b0, -1, -1);
         else
            do_op(o, pick(), pick(), 1'($urandom), 1'($urandom), -1, -1);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'h0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, alongside the 32-bit ALU. It takes the same a/b operands from ID/EX.
- Owns the architectural HI/LO registers. Results reach the EX result mux via mfhi/mflo.
- Busy stalls the pipeline on HI/LO hazards.
- One result bit per cycle: 32 iteration cycles plus 1 finalize cycle.

Parameters:
- WIDTH, 32: operand and HI/LO width. Iteration count equals WIDTH.

Ports:
- clk, input, 1: clock. Rising edge.
- rst_n, input, 1: synchronous reset, active low.
- start, input, 1: launch operation; sampled only in IDLE.
- op, input, 3: 000 mult, 001 multu, 010 div, 011 divu, 100 madd, 101 maddu (100/101 see Optional Feature). Codes 11x: start ignored.
- a, input, WIDTH: rs operand (multiplicand/dividend; data for mthi/mtlo).
- b, input, WIDTH: rt operand (multiplier/divisor).
- mthi, input, 1: write a into HI.
- mtlo, input, 1: write a into LO.
- busy, output, 1: operation in flight; pipeline must stall mfhi/mflo/mult/div.
- done, output, 1: one-cycle pulse, HI/LO just updated.
- div_by_zero, output, 1: pulses with done when div/divu had b==0.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; internal counters/accumulators cleared. Reset mid-operation aborts it with no HI/LO write.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start with valid op → latch |a|,|b| (signed ops use magnitudes; unsigned use raw values), result sign flags and count=WIDTH-1.
  - Go to MUL or DIV; busy=1 from the next cycle.
  - start in IDLE takes priority over mthi/mtlo in the same cycle; those writes are dropped.
  - Without start: mthi→hi<=a, mtlo→lo<=a. Both may fire together.
- MUL: unsigned shift-add over a 2*WIDTH product register, one multiplier bit per cycle, LSB first. After count hits 0 → FIN.
- DIV: restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder. After count hits 0 → FIN.
- Divide by zero (div/divu, b==0) detected in IDLE:
  - Goes directly to FIN; no iterations.
  - FIN asserts done and div_by_zero; hi/lo unchanged.
- FIN (1 cycle):
  - Apply sign correction:
    - mult: negate the 64-bit product if sign(a)!=sign(b).
    - div: negate quotient if signs differ; remainder takes the sign of the dividend; quotient truncates toward zero.
  - Write results: mult → {hi,lo}=product. div → lo=quotient, hi=remainder.
  - Next edge: state=IDLE, busy=0, done=1 for exactly one cycle.
- Latency:
  - start sampled at edge 0; busy=1 after edges 0..32; hi/lo updated and done=1 after edge 33; busy=0 after edge 33.
  - Divide by zero: done after edge 1.
- Width and overflow:
  - Signed magnitude of 0x80000000 is 0x80000000 unsigned.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. No trap, no flag.
- While busy: start, mthi and mtlo are ignored; hi/lo hold their old values until FIN.
- hi/lo outputs are the registers directly; no combinational path from a/b.

Optional Feature:
- Macro: MULDIV_ACC_EN.
- Defined: op 100/101 run signed/unsigned multiply as normal. In FIN, {hi,lo} <= {hi,lo} + product, using 64-bit wrap-around. Latency is identical to mult.
- Not defined: 100/101 behave exactly as 000/001, with no accumulate; no accumulate adder is synthesized.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3) → busy for 33 cycles; done after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- divu a=100, b=7 → lo=14, hi=2. div a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- mthi a=0x1234, then div a=5, b=0 → done and div_by_zero after edge 1; hi=0x1234 and lo unchanged.
- During a multu of 0xFFFFFFFF*0xFFFFFFFF, pulse start (op=010) and mthi at cycle 10 → both ignored; result hi=0xFFFFFFFE, lo=0x00000001.
- Drop rst_n at cycle 15 of a mult → next edge: busy=0, hi=lo=0, no done. A new mult 3*4 afterwards gives lo=12, hi=0.
- With MULDIV_ACC_EN: hi=0, lo=0xFFFFFFFF, then maddu a=1, b=1 → hi=1, lo=0. Without the macro, the same stimulus gives hi=0, lo=1.
